multicycle_control_fsm: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder; sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives datapath enables and muxes from the current state.
- Adds memory ready handshake with timeout, JAL/JALR/LUI/AUIPC support and an illegal-opcode trap.
- Sits between the instruction register and the shared-memory datapath.

---
 rtl/multicycle_control_fsm_pkg.sv | 64 ++++++
 rtl/multicycle_control_fsm_timer.sv | 30 +++
 rtl/multicycle_control_fsm.sv | 150 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, state enum,
// datapath select codes and the DECODE dispatch function.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM    = 4'd6,
    S_LDWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_UPPER  = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  function automatic state_t decode_next(input logic [6:0] op, input logic has_jump);
    state_t s;
    case (op)
      OP_R, OP_I:        s = S_EXEC;
      OP_LOAD, OP_STORE: s = S_ADDR;
      OP_BRANCH:         s = S_BRANCH;
      OP_JAL, OP_JALR:   s = has_jump ? S_JUMP : S_TRAP;
      OP_LUI, OP_AUIPC:  s = S_UPPER;
      default:           s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_timer.sv
// Wait-cycle counter for FETCH/MEM accesses; flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // Expired marks the MEM_TIMEOUT-th wait cycle, so the FSM can still let a
  // same-cycle mem_ready win before committing to TRAP.
  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// datapath enables/muxes from the registered state, with memory timeout and trap.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUOP_W     = 2,
  parameter bit HAS_JUMP    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_run,
  input  logic [6:0]         i_opcode,
  input  logic               i_zero,
  input  logic               i_mem_ready,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic               o_iord,
  output logic               o_ir_write,
  output logic               o_pc_write,
  output logic               o_reg_write,
  output logic [1:0]         o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [1:0]         o_wb_sel,
  output logic [1:0]         o_pc_src,
  output logic               o_trap,
  output logic [3:0]         o_state
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_after;
  logic       w_waiting;
  logic       w_expired;
  logic [1:0] w_alu_op;

  // Counter restarts whenever we are not waiting or the access completes.
  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_waiting || i_mem_ready),
    .i_enable (w_waiting && !i_mem_ready),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Dropping run lets the current instruction finish, then parks in IDLE.
  assign w_after = i_run ? S_FETCH : S_IDLE;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_run) w_next = S_FETCH;
      S_FETCH: begin
        if (i_mem_ready)    w_next = S_DECODE;
        else if (w_expired) w_next = S_TRAP;
      end
      S_DECODE: w_next = decode_next(i_opcode, HAS_JUMP);
      S_EXEC:   w_next = S_ALUWB;
      S_ADDR:   w_next = S_MEM;
      S_MEM: begin
        if (i_mem_ready)    w_next = (i_opcode == OP_STORE) ? w_after : S_LDWB;
        else if (w_expired) w_next = S_TRAP;
      end
      S_ALUWB, S_LDWB, S_BRANCH, S_JUMP, S_UPPER: w_next = w_after;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_iord      = 1'b0;
    o_ir_write  = 1'b0;
    o_pc_write  = 1'b0;
    o_reg_write = 1'b0;
    o_alu_src_a = SRCA_PC;
    o_alu_src_b = SRCB_RS2;
    w_alu_op    = ALU_ADD;
    o_wb_sel    = WB_ALU;
    o_pc_src    = PC_ALU;
    o_trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req   = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: o_alu_src_b = SRCB_IMM;
      S_EXEC: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = (i_opcode == OP_R) ? SRCB_RS2 : SRCB_IMM;
        w_alu_op    = ALU_FUNCT;
      end
      S_ALUWB:  o_reg_write = 1'b1;
      S_ADDR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
        o_mem_we  = (i_opcode == OP_STORE);
      end
      S_LDWB: begin
        o_reg_write = 1'b1;
        o_wb_sel    = WB_MEM;
      end
      S_BRANCH: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_RS2;
        w_alu_op    = ALU_SUB;
        o_pc_write  = i_zero;
        o_pc_src    = PC_BRANCH;
      end
      S_JUMP: begin
        o_reg_write = 1'b1;
        o_wb_sel    = WB_PC4;
        o_pc_write  = 1'b1;
        o_pc_src    = PC_JUMP;
      end
      S_UPPER: begin
        o_alu_src_a = (i_opcode == OP_LUI) ? SRCA_ZERO : SRCA_PC;
        o_alu_src_b = SRCB_IMM;
        w_alu_op    = (i_opcode == OP_LUI) ? ALU_PASSB : ALU_ADD;
        o_reg_write = 1'b1;
      end
      S_TRAP:   o_trap = 1'b1;
      default: ;
    endcase
  end

  assign o_alu_op = ALUOP_W'(w_alu_op);
  assign o_state  = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle stimulus and expected
// output vectors are queued together, then replayed and compared cycle by cycle.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel, pc_src;
  logic [3:0] state_o;

  logic       nj_mem_req, nj_mem_we, nj_iord, nj_ir_write, nj_pc_write, nj_reg_write, nj_trap;
  logic [1:0] nj_alu_src_a, nj_alu_src_b, nj_alu_op, nj_wb_sel, nj_pc_src;
  logic [3:0] nj_state_o;

  logic [20:0] obs, nj_obs;
  logic [20:0] exp_q[$];
  logic [20:0] nj_q[$];
  logic [9:0]  in_q[$];

  int checks = 0;
  int errors = 0;

  logic [20:0] v_idle, v_fetch_rdy, v_fetch_wait, v_decode, v_exec_r, v_exec_i, v_aluwb;
  logic [20:0] v_addr, v_mem_ld, v_mem_st, v_ldwb, v_br_t, v_br_nt, v_jump, v_lui, v_auipc, v_trap;

  multicycle_control_fsm #(.MEM_TIMEOUT(4), .ALUOP_W(2), .HAS_JUMP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_opcode(opcode), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_iord(iord),
    .o_ir_write(ir_write), .o_pc_write(pc_write), .o_reg_write(reg_write),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
    .o_wb_sel(wb_sel), .o_pc_src(pc_src), .o_trap(trap), .o_state(state_o)
  );

  multicycle_control_fsm #(.MEM_TIMEOUT(4), .ALUOP_W(2), .HAS_JUMP(1'b0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_opcode(opcode), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_mem_req(nj_mem_req), .o_mem_we(nj_mem_we), .o_iord(nj_iord),
    .o_ir_write(nj_ir_write), .o_pc_write(nj_pc_write), .o_reg_write(nj_reg_write),
    .o_alu_src_a(nj_alu_src_a), .o_alu_src_b(nj_alu_src_b), .o_alu_op(nj_alu_op),
    .o_wb_sel(nj_wb_sel), .o_pc_src(nj_pc_src), .o_trap(nj_trap), .o_state(nj_state_o)
  );

  assign obs = {state_o, mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, wb_sel, pc_src, trap};
  assign nj_obs = {nj_state_o, nj_mem_req, nj_mem_we, nj_iord, nj_ir_write, nj_pc_write,
                   nj_reg_write, nj_alu_src_a, nj_alu_src_b, nj_alu_op, nj_wb_sel, nj_pc_src, nj_trap};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] ev(input logic [3:0] st, input logic mreq, input logic mwe,
      input logic io, input logic irw, input logic pcw, input logic rw, input logic [1:0] a,
      input logic [1:0] b, input logic [1:0] op, input logic [1:0] wb, input logic [1:0] pcs,
      input logic tr);
    return {st, mreq, mwe, io, irw, pcw, rw, a, b, op, wb, pcs, tr};
  endfunction

  function automatic void init_vectors();
    v_idle       = ev(S_IDLE,   N, N, N, N, N, N, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, N);
    v_fetch_rdy  = ev(S_FETCH,  Y, N, N, Y, Y, N, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, N);
    v_fetch_wait = ev(S_FETCH,  Y, N, N, N, N, N, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, N);
    v_decode     = ev(S_DECODE, N, N, N, N, N, N, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, N);
    v_exec_r     = ev(S_EXEC,   N, N, N, N, N, N, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, N);
    v_exec_i     = ev(S_EXEC,   N, N, N, N, N, N, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, N);
    v_aluwb      = ev(S_ALUWB,  N, N, N, N, N, Y, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, N);
    v_addr       = ev(S_ADDR,   N, N, N, N, N, N, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, N);
    v_mem_ld     = ev(S_MEM,    Y, N, Y, N, N, N, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, N);
    v_mem_st     = ev(S_MEM,    Y, Y, Y, N, N, N, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, N);
    v_ldwb       = ev(S_LDWB,   N, N, N, N, N, Y, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, N);
    v_br_t       = ev(S_BRANCH, N, N, N, N, Y, N, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, N);
    v_br_nt      = ev(S_BRANCH, N, N, N, N, N, N, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, N);
    v_jump       = ev(S_JUMP,   N, N, N, N, Y, Y, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, N);
    v_lui        = ev(S_UPPER,  N, N, N, N, N, Y, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, N);
    v_auipc      = ev(S_UPPER,  N, N, N, N, N, Y, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, N);
    v_trap       = ev(S_TRAP,   N, N, N, N, N, N, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, Y);
  endfunction

  // driver
  function automatic void push(input logic r, input logic [6:0] op, input logic z,
                               input logic mr, input logic [20:0] e);
    in_q.push_back({r, op, z, mr});
    exp_q.push_back(e);
  endfunction

  task automatic drive_next();
    logic [9:0] v;
    if (in_q.size() != 0) begin
      v = in_q.pop_front();
      run = v[9]; opcode = v[8:2]; zero = v[1]; mem_ready = v[0];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; opcode = OP_R; mem_ready = 1'b1; zero = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (obs !== v_idle) begin errors++; $display("FAIL reset got %h exp %h", obs, v_idle); end
    checks++;
    if (nj_obs !== v_idle) begin errors++; $display("FAIL reset_nj got %h exp %h", nj_obs, v_idle); end
    do_reset();
  endtask

  task automatic test_r_type();
    int cyc = 0;
    logic [20:0] e;
    push(Y, OP_R, N, Y, v_idle);
    push(Y, OP_R, N, Y, v_fetch_rdy);
    push(Y, OP_R, N, Y, v_decode);
    push(Y, OP_R, N, Y, v_exec_r);
    push(Y, OP_I, N, Y, v_aluwb);
    push(Y, OP_I, N, Y, v_fetch_rdy);
    push(Y, OP_I, N, Y, v_decode);
    push(N, OP_I, N, Y, v_exec_i);
    push(N, OP_I, N, Y, v_aluwb);
    push(N, OP_I, N, Y, v_idle);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL r_type cyc %0d got %h exp %h", cyc, obs, e); end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    int cyc = 0;
    logic [20:0] e;
    push(Y, OP_LOAD, N, Y, v_idle);
    push(Y, OP_LOAD, N, Y, v_fetch_rdy);
    push(Y, OP_LOAD, N, Y, v_decode);
    push(Y, OP_LOAD, N, Y, v_addr);
    push(Y, OP_LOAD, N, N, v_mem_ld);
    push(Y, OP_LOAD, N, N, v_mem_ld);
    push(Y, OP_LOAD, N, N, v_mem_ld);
    push(Y, OP_LOAD, N, Y, v_mem_ld);
    push(Y, OP_STORE, N, Y, v_ldwb);
    push(Y, OP_STORE, N, Y, v_fetch_rdy);
    push(Y, OP_STORE, N, Y, v_decode);
    push(Y, OP_STORE, N, Y, v_addr);
    push(Y, OP_STORE, N, N, v_mem_st);
    push(N, OP_STORE, N, Y, v_mem_st);
    push(N, OP_STORE, N, Y, v_idle);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL load_store cyc %0d got %h exp %h", cyc, obs, e); end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    int cyc = 0;
    logic [20:0] e;
    push(Y, OP_BRANCH, Y, Y, v_idle);
    push(Y, OP_BRANCH, Y, Y, v_fetch_rdy);
    push(Y, OP_BRANCH, Y, Y, v_decode);
    push(Y, OP_BRANCH, Y, Y, v_br_t);
    push(Y, OP_BRANCH, N, Y, v_fetch_rdy);
    push(Y, OP_BRANCH, N, Y, v_decode);
    push(N, OP_BRANCH, N, Y, v_br_nt);
    push(N, OP_BRANCH, N, Y, v_idle);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL branch cyc %0d got %h exp %h", cyc, obs, e); end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_jump_upper();
    int cyc = 0;
    logic [20:0] e;
    do_reset();
    push(Y, OP_JALR, N, Y, v_idle);      nj_q.push_back(v_idle);
    push(Y, OP_JALR, N, Y, v_fetch_rdy); nj_q.push_back(v_fetch_rdy);
    push(Y, OP_JALR, N, Y, v_decode);    nj_q.push_back(v_decode);
    push(Y, OP_JAL,  N, Y, v_jump);      nj_q.push_back(v_trap);
    push(Y, OP_JAL,  N, Y, v_fetch_rdy); nj_q.push_back(v_trap);
    push(Y, OP_JAL,  N, Y, v_decode);    nj_q.push_back(v_trap);
    push(Y, OP_LUI,  N, Y, v_jump);      nj_q.push_back(v_trap);
    push(Y, OP_LUI,  N, Y, v_fetch_rdy); nj_q.push_back(v_trap);
    push(Y, OP_LUI,  N, Y, v_decode);    nj_q.push_back(v_trap);
    push(Y, OP_LUI,  N, Y, v_lui);       nj_q.push_back(v_trap);
    push(Y, OP_AUIPC, N, Y, v_fetch_rdy); nj_q.push_back(v_trap);
    push(Y, OP_AUIPC, N, Y, v_decode);   nj_q.push_back(v_trap);
    push(N, OP_AUIPC, N, Y, v_auipc);    nj_q.push_back(v_trap);
    push(N, OP_AUIPC, N, Y, v_idle);     nj_q.push_back(v_trap);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL jump_upper cyc %0d got %h exp %h", cyc, obs, e); end
      e = nj_q.pop_front(); checks++;
      if (nj_obs !== e) begin errors++; $display("FAIL no_jump cyc %0d got %h exp %h", cyc, nj_obs, e); end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    logic [20:0] e;
    do_reset();
    push(Y, OP_R, N, N, v_idle);
    repeat (4) push(Y, OP_R, N, N, v_fetch_wait);
    push(N, OP_R, N, N, v_trap);
    push(Y, OP_R, N, Y, v_trap);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL fetch_timeout cyc %0d got %h exp %h", cyc, obs, e); end
      cyc++; @(posedge clk); #1;
    end
    do_reset();
    cyc = 0;
    push(Y, OP_R, N, N, v_idle);
    repeat (3) push(Y, OP_R, N, N, v_fetch_wait);
    push(Y, OP_R, N, Y, v_fetch_rdy);
    push(Y, OP_R, N, Y, v_decode);
    push(Y, OP_R, N, Y, v_exec_r);
    push(N, OP_R, N, Y, v_aluwb);
    push(N, OP_R, N, Y, v_idle);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL limit_ready cyc %0d got %h exp %h", cyc, obs, e); end
      cyc++; @(posedge clk); #1;
    end
    do_reset();
    cyc = 0;
    push(Y, OP_LOAD, N, Y, v_idle);
    push(Y, OP_LOAD, N, Y, v_fetch_rdy);
    push(Y, OP_LOAD, N, Y, v_decode);
    push(Y, OP_LOAD, N, Y, v_addr);
    repeat (4) push(Y, OP_LOAD, N, N, v_mem_ld);
    push(Y, OP_LOAD, N, N, v_trap);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_timeout cyc %0d got %h exp %h", cyc, obs, e); end
      cyc++; @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_and_async_reset();
    int cyc = 0;
    logic [20:0] e;
    do_reset();
    push(Y, 7'b1111111, N, Y, v_idle);
    push(Y, 7'b1111111, N, Y, v_fetch_rdy);
    push(Y, 7'b1111111, N, Y, v_decode);
    push(Y, 7'b1111111, N, Y, v_trap);
    push(N, 7'b1111111, N, Y, v_trap);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL illegal cyc %0d got %h exp %h", cyc, obs, e); end
      cyc++; @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 checks++;
    if (obs !== v_idle) begin errors++; $display("FAIL trap_clear got %h exp %h", obs, v_idle); end
    do_reset();
    cyc = 0;
    push(Y, OP_LOAD, N, Y, v_idle);
    push(Y, OP_LOAD, N, Y, v_fetch_rdy);
    push(Y, OP_LOAD, N, Y, v_decode);
    push(Y, OP_LOAD, N, Y, v_addr);
    push(Y, OP_LOAD, N, N, v_mem_ld);
    push(Y, OP_LOAD, N, N, v_mem_ld);
    while (exp_q.size() != 0) begin
      drive_next(); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL pre_reset cyc %0d got %h exp %h", cyc, obs, e); end
      cyc++; @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 checks++;
    if (obs !== v_idle) begin errors++; $display("FAIL async_reset got %h exp %h", obs, v_idle); end
    @(posedge clk); #2 checks++;
    if (obs !== v_idle) begin errors++; $display("FAIL reset_hold got %h exp %h", obs, v_idle); end
    do_reset();
  endtask

  initial begin
    init_vectors();
    rst_n = 1'b0; run = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_load_store();
    test_branch();
    test_jump_upper();
    test_timeout();
    test_illegal_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
